// File: rtl/debug_control_unit.sv
// Debug sequencer between the UART link and the MIPS core: loads the program
// one byte at a time, runs the core continuously or step by step, and reports PC and cycle count.
module debug_control_unit #(
  parameter int LEN       = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 tx_done,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 imem_we,
  output logic [ADDR_BITS-1:0] imem_addr,
  output logic [LEN-1:0]       imem_data,
  output logic                 mips_enable,
  output logic                 mips_reset,
  input  logic [LEN-1:0]       pc_in,
  input  logic                 halt_in,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROG      = 3'd1,
    WAIT_MODE = 3'd2,
    RUN       = 3'd3,
    STEP_WAIT = 3'd4,
    STEP_EXEC = 3'd5,
    SEND      = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_CONT   = 8'h02;
  localparam logic [7:0] CMD_STEPM  = 8'h03;
  localparam logic [7:0] CMD_REPROG = 8'h05;
  localparam logic [7:0] CMD_STEP   = 8'h06;
  localparam logic [5:0] OP_HALT    = 6'b111111;
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};

  state_t             state, next_state;
  logic [1:0]         byte_idx;
  logic [23:0]        word_buf;
  logic [LEN-1:0]     cycle_cnt;
  logic [2*LEN-1:0]   snap;
  logic [2:0]         tx_cnt;
  logic               ret_done;
  logic               last_word;
  logic               tx_ack;

  // The word being written ends loading if it is HALT or fills the last address.
  assign last_word = imem_we && ((imem_data[LEN-1:LEN-6] == OP_HALT) || (imem_addr == ADDR_MAX));
  assign tx_ack    = tx_start && tx_done;
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    mips_enable = 1'b0;
    mips_reset  = 1'b0;
    case (state)
      IDLE: begin
        mips_reset = 1'b1;
        if (rx_done && rx_data == CMD_START) next_state = PROG;
      end
      PROG: begin
        mips_reset = 1'b1;
        if (last_word) next_state = WAIT_MODE;
      end
      WAIT_MODE: begin
        mips_reset = 1'b1;
        if (rx_done && rx_data == CMD_CONT)       next_state = RUN;
        else if (rx_done && rx_data == CMD_STEPM) next_state = STEP_WAIT;
      end
      RUN: begin
        mips_enable = 1'b1;
        if (halt_in) next_state = SEND;
      end
      STEP_WAIT: begin
        if (rx_done && rx_data == CMD_STEP) next_state = STEP_EXEC;
      end
      STEP_EXEC: begin
        mips_enable = 1'b1;
        next_state  = SEND;
      end
      SEND: begin
        if (tx_ack && tx_cnt == 3'd7) next_state = ret_done ? DONE : STEP_WAIT;
      end
      DONE: begin
        if (rx_done && rx_data == CMD_REPROG) next_state = PROG;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start  <= 1'b0;
      tx_data   <= 8'd0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      byte_idx  <= 2'd0;
      word_buf  <= 24'd0;
      cycle_cnt <= '0;
      snap      <= '0;
      tx_cnt    <= 3'd0;
      ret_done  <= 1'b0;
    end else begin
      imem_we <= 1'b0;

      if (next_state == PROG && state != PROG) begin
        imem_addr <= '0;
        byte_idx  <= 2'd0;
      end

      if (state == PROG) begin
        if (imem_we && imem_addr != ADDR_MAX) imem_addr <= imem_addr + ADDR_BITS'(1);
        // Bytes arriving while loading finishes are dropped with the state change.
        if (rx_done && next_state == PROG) begin
          if (byte_idx == 2'd3) begin
            imem_data <= {rx_data, word_buf};
            imem_we   <= 1'b1;
            byte_idx  <= 2'd0;
          end else begin
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
      end

      if ((next_state == WAIT_MODE && state != WAIT_MODE) ||
          (state == DONE && next_state == PROG))
        cycle_cnt <= '0;
      else if (mips_enable)
        cycle_cnt <= cycle_cnt + LEN'(1);

      // SEND is only entered from an enabled cycle, so the snapshot includes its count.
      if (next_state == SEND && state != SEND) begin
        snap     <= {cycle_cnt + LEN'(1), pc_in};
        tx_data  <= pc_in[7:0];
        tx_start <= 1'b1;
        tx_cnt   <= 3'd0;
        ret_done <= halt_in;
      end else if (state == SEND) begin
        if (tx_ack) begin
          tx_start <= 1'b0;
          snap     <= snap >> 8;
          tx_cnt   <= tx_cnt + 3'd1;
        end else if (!tx_start) begin
          tx_start <= 1'b1;
          tx_data  <= snap[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_control_unit.sv
// Directed bench for debug_control_unit: program load, continuous run, step mode,
// reprogramming, end-of-memory handling (small instance) and reset mid-word.
module tb_debug_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        halt_in = 1'b0;
  logic [31:0] pc_in = 32'd0;

  logic [7:0]  tx_data;
  logic        tx_start, imem_we, mips_enable, mips_reset;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [2:0]  state_out;

  logic [7:0]  s_tx_data;
  logic        s_tx_start, s_imem_we, s_mips_enable, s_mips_reset;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_data;
  logic [2:0]  s_state_out;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int gap_err = 0;
  int gap_len = 0;
  int tx_wait = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];
  logic [1:0]  swa[$];
  logic [31:0] swd[$];
  logic [7:0]  txq[$];

  always #5 clk = ~clk;

  debug_control_unit #(.LEN(32), .ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .mips_enable(mips_enable), .mips_reset(mips_reset),
    .pc_in(pc_in), .halt_in(halt_in), .state_out(state_out)
  );

  debug_control_unit #(.LEN(32), .ADDR_BITS(2)) dut_s (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_data(s_tx_data), .tx_start(s_tx_start), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_data(s_imem_data), .mips_enable(s_mips_enable), .mips_reset(s_mips_reset),
    .pc_in(pc_in), .halt_in(halt_in), .state_out(s_state_out)
  );

  always @(posedge clk) begin
    if (imem_we) begin wa.push_back(imem_addr); wd.push_back(imem_data); end
    if (s_imem_we) begin swa.push_back(s_imem_addr); swd.push_back(s_imem_data); end
    if (tx_start && tx_done) txq.push_back(tx_data);
    if (mips_enable) en_cnt++;
  end

  // UART tx model: acknowledge each byte after it has been requested for a few cycles.
  always @(negedge clk) begin
    if (tx_done) begin
      tx_done = 1'b0;
      tx_wait = 0;
    end else if (tx_start) begin
      if (tx_wait == 2) begin tx_done = 1'b1; tx_wait = 0; end
      else tx_wait++;
    end else tx_wait = 0;
    if (state_out == 3'd6) begin
      if (!tx_start) gap_len++;
      else begin
        if (gap_len > 0 && gap_len != 1) gap_err++;
        gap_len = 0;
      end
    end else gap_len = 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
    int n = 0;
    while (state_out !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, {61'd0, state_out}, {61'd0, s});
  endtask

  task automatic check_tx(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    logic [63:0] exp;
    logic [7:0]  got;
    exp = {cnt, pc};
    check({tag, "_len"}, 64'(txq.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), {56'd0, got}, {56'd0, exp[i*8 +: 8]});
    end
  endtask

  task automatic run_cycles(input int n, input logic [31:0] pc);
    repeat (n - 1) @(negedge clk);
    pc_in   = pc;
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_tx_start", {63'd0, tx_start}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_imem_we", {63'd0, imem_we}, 64'd0);
    check("rst_imem_addr", {54'd0, imem_addr}, 64'd0);
    check("rst_imem_data", {32'd0, imem_data}, 64'd0);
    check("rst_mips_enable", {63'd0, mips_enable}, 64'd0);
    check("rst_mips_reset", {63'd0, mips_reset}, 64'd1);
    check("rst_state", {61'd0, state_out}, 64'd0);

    // First word of a program
    send_byte(8'h01);
    check("start_state", {61'd0, state_out}, 64'd1);
    send_word(32'h24010020);
    check("w0_we", {63'd0, imem_we}, 64'd1);
    check("w0_addr", {54'd0, imem_addr}, 64'd0);
    check("w0_data", {32'd0, imem_data}, 64'h24010020);
    @(negedge clk);
    check("w0_we_drop", {63'd0, imem_we}, 64'd0);
    check("w0_addr_inc", {54'd0, imem_addr}, 64'd1);
    check("w0_state", {61'd0, state_out}, 64'd1);
    check("w0_count", 64'(wa.size()), 64'd1);

    // HALT word, then continuous run halting on the 5th enabled cycle
    send_word(32'hFC000000);
    check("w1_addr", {54'd0, imem_addr}, 64'd1);
    @(negedge clk);
    check("halt_wait", {61'd0, state_out}, 64'd2);
    check("wait_mreset", {63'd0, mips_reset}, 64'd1);
    check("w1_count", 64'(wa.size()), 64'd2);
    txq.delete();
    en_cnt = 0;
    send_byte(8'h02);
    check("run_state", {61'd0, state_out}, 64'd3);
    check("run_enable", {63'd0, mips_enable}, 64'd1);
    check("run_mreset", {63'd0, mips_reset}, 64'd0);
    run_cycles(5, 32'h00000008);
    check("send_state", {61'd0, state_out}, 64'd6);
    check("send_enable", {63'd0, mips_enable}, 64'd0);
    wait_state("run_done", 3'd7, 200);
    check_tx("run_tx", 32'h00000008, 32'd5);
    check("run_en_cycles", 64'(en_cnt), 64'd5);
    check("done_enable", {63'd0, mips_enable}, 64'd0);
    check("done_mreset", {63'd0, mips_reset}, 64'd0);
    check("done_tx_start", {63'd0, tx_start}, 64'd0);

    // Reprogram from DONE and check the counter restarts
    wa.delete(); wd.delete();
    send_byte(8'h05);
    check("reprog_state", {61'd0, state_out}, 64'd1);
    check("reprog_mreset", {63'd0, mips_reset}, 64'd1);
    check("reprog_addr", {54'd0, imem_addr}, 64'd0);
    send_word(32'h24020003);
    send_word(32'hFC000000);
    @(negedge clk);
    check("reprog_writes", 64'(wa.size()), 64'd2);
    check("reprog_a0", {54'd0, (wa.size() > 0) ? wa[0] : 10'hxxx}, 64'd0);
    check("reprog_d0", {32'd0, (wd.size() > 0) ? wd[0] : 32'hxxxxxxxx}, 64'h24020003);
    check("reprog_a1", {54'd0, (wa.size() > 1) ? wa[1] : 10'hxxx}, 64'd1);
    check("reprog_d1", {32'd0, (wd.size() > 1) ? wd[1] : 32'hxxxxxxxx}, 64'hFC000000);
    check("reprog_wait", {61'd0, state_out}, 64'd2);
    txq.delete();
    send_byte(8'h02);
    run_cycles(3, 32'h00000004);
    wait_state("rerun_done", 3'd7, 200);
    check_tx("rerun_tx", 32'h00000004, 32'd3);

    // Step-by-step mode
    send_byte(8'h05);
    send_word(32'h24010020);
    send_word(32'hFC000000);
    @(negedge clk);
    send_byte(8'h03);
    check("stepw_state", {61'd0, state_out}, 64'd4);
    check("stepw_enable", {63'd0, mips_enable}, 64'd0);
    txq.delete();
    en_cnt = 0;
    pc_in = 32'h00000004;
    send_byte(8'h06);
    check("stepx_state", {61'd0, state_out}, 64'd5);
    check("stepx_enable", {63'd0, mips_enable}, 64'd1);
    wait_state("step1_back", 3'd4, 200);
    check_tx("step1_tx", 32'h00000004, 32'd1);
    check("step1_en", 64'(en_cnt), 64'd1);
    txq.delete();
    pc_in = 32'h00000008;
    send_byte(8'h06);
    wait_state("step2_back", 3'd4, 200);
    check_tx("step2_tx", 32'h00000008, 32'd2);
    check("step2_en", 64'(en_cnt), 64'd2);

    // Small instance: memory fills at address 3
    do_reset();
    swa.delete(); swd.delete();
    send_byte(8'h01);
    for (int k = 0; k < 4; k++) send_word(32'h11 * (k + 1));
    @(negedge clk);
    check("small_state", {61'd0, s_state_out}, 64'd2);
    check("small_writes", 64'(swa.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("small_a%0d", k), {62'd0, (k < swa.size()) ? swa[k] : 2'bxx}, 64'(k));
      check($sformatf("small_d%0d", k), {32'd0, (k < swd.size()) ? swd[k] : 32'hxxxxxxxx},
            64'(32'h11 * (k + 1)));
    end
    send_word(32'h44444444);
    @(negedge clk);
    check("small_extra_state", {61'd0, s_state_out}, 64'd2);
    check("small_extra_writes", 64'(swa.size()), 64'd4);
    check("small_addr_hold", {62'd0, s_imem_addr}, 64'd3);

    // Reset in the middle of a word
    do_reset();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wa.delete(); wd.delete();
    do_reset();
    check("midrst_state", {61'd0, state_out}, 64'd0);
    check("midrst_we", {63'd0, imem_we}, 64'd0);
    send_byte(8'h01);
    send_word(32'h12345678);
    @(negedge clk);
    check("midrst_writes", 64'(wa.size()), 64'd1);
    check("midrst_a0", {54'd0, (wa.size() > 0) ? wa[0] : 10'hxxx}, 64'd0);
    check("midrst_d0", {32'd0, (wd.size() > 0) ? wd[0] : 32'hxxxxxxxx}, 64'h12345678);

    check("tx_gap_one_cycle", 64'(gap_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
